// File: rtl/mastermind_pkg.sv
// rtl/mastermind_pkg.sv - shared types and encodings for the Mastermind controller
//
// Purpose: FSM state enum, code geometry, winner and player encodings, and a
//          helper that turns two final scores into a winner code.
// Ports:   none (package).

package mastermind_pkg;

  localparam int DIGITS  = 4;
  localparam int DIGIT_W = 3;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CODE      = 3'd1,
    GUESS     = 3'd2,
    ROUND_END = 3'd3,
    GAME_OVER = 3'd4
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_A    = 2'b01;
  localparam logic [1:0] WIN_B    = 2'b10;
  localparam logic [1:0] WIN_TIE  = 2'b11;

  localparam logic PLAYER_A = 1'b0;
  localparam logic PLAYER_B = 1'b1;

  // Scores are zero-extended to 16 bits by the caller so one helper serves
  // every SCORE_W up to 16.
  function automatic logic [1:0] winner_of(input logic [15:0] a, input logic [15:0] b);
    if (a > b)      return WIN_A;
    else if (b > a) return WIN_B;
    else            return WIN_TIE;
  endfunction

endpackage

// File: rtl/mastermind_game_ctrl_if.sv
// rtl/mastermind_game_ctrl_if.sv - handshake/status bundle between the game controller and its peers
//
// Purpose: groups the start/code/guess handshakes and the phase, counter and
//          score outputs of mastermind_game_ctrl.
// Modports:
//   master - environment side: drives start, code_valid, guess_valid, exact
//   slave  - controller side: receives the above, drives take_code, guess_req,
//            active_p, guess_num, round_num, score_a, score_b, round_over,
//            game_over, winner

interface mastermind_game_ctrl_if #(
  parameter int DIGITS      = 4,
  parameter int MAX_GUESSES = 7,
  parameter int ROUNDS      = 4,
  parameter int SCORE_W     = 5
);

  localparam int EXACT_W = $clog2(DIGITS + 1);
  localparam int GNUM_W  = $clog2(MAX_GUESSES + 1);
  localparam int RNUM_W  = $clog2(ROUNDS + 1);

  logic               start;
  logic               code_valid;
  logic               guess_valid;
  logic [EXACT_W-1:0] exact;
  logic               take_code;
  logic               guess_req;
  logic               active_p;
  logic [GNUM_W-1:0]  guess_num;
  logic [RNUM_W-1:0]  round_num;
  logic [SCORE_W-1:0] score_a;
  logic [SCORE_W-1:0] score_b;
  logic               round_over;
  logic               game_over;
  logic [1:0]         winner;

  modport master (
    output start, code_valid, guess_valid, exact,
    input  take_code, guess_req, active_p, guess_num, round_num,
           score_a, score_b, round_over, game_over, winner
  );

  modport slave (
    input  start, code_valid, guess_valid, exact,
    output take_code, guess_req, active_p, guess_num, round_num,
           score_a, score_b, round_over, game_over, winner
  );

endinterface

// File: rtl/sat_score_counter.sv
// rtl/sat_score_counter.sv - saturating per-player score counter
//
// Purpose: adds 0, 1 or 2 per cycle and sticks at the all-ones value.
// Ports:
//   clk    in  system clock
//   reset  in  synchronous active-high reset
//   clear  in  synchronous clear (new game); wins over inc
//   inc    in  increment amount 0..2
//   score  out current score

module sat_score_counter #(
  parameter int SCORE_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic [1:0]         inc,
  output logic [SCORE_W-1:0] score
);

  localparam logic [SCORE_W:0] SAT_MAX = {1'b0, {SCORE_W{1'b1}}};

  // One extra bit so an overflow is visible before it wraps.
  logic [SCORE_W:0] sum;
  assign sum = {1'b0, score} + (SCORE_W + 1)'(inc);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      score <= '0;
    end else if (sum > SAT_MAX) begin
      score <= {SCORE_W{1'b1}};
    end else begin
      score <= sum[SCORE_W-1:0];
    end
  end

endmodule

// File: rtl/mastermind_game_ctrl.sv
// rtl/mastermind_game_ctrl.sv - round/turn sequencer for the Mastermind machine
//
// Purpose: runs ROUNDS rounds, alternating the code maker between A and B;
//          per round collects one secret code then guesses until a full match
//          or MAX_GUESSES, scoring the maker, and declares the winner.
// Ports:
//   clk    in  system clock
//   reset  in  synchronous active-high reset
//   bus    slave side of mastermind_game_ctrl_if (handshakes in, phase,
//          counters, scores and winner out)

module mastermind_game_ctrl #(
  parameter int DIGITS      = mastermind_pkg::DIGITS,
  parameter int MAX_GUESSES = 7,
  parameter int ROUNDS      = 4,
  parameter int SCORE_W     = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  mastermind_game_ctrl_if.slave bus
);

  import mastermind_pkg::*;

  localparam int EXACT_W = $clog2(DIGITS + 1);
  localparam int GNUM_W  = $clog2(MAX_GUESSES + 1);
  localparam int RNUM_W  = $clog2(ROUNDS + 1);

  state_t             state;
  logic               take_code_q;
  logic               guess_req_q;
  logic               round_over_q;
  logic               game_over_q;
  logic               active_p_q;
  logic [1:0]         winner_q;
  logic [GNUM_W-1:0]  guess_num_q;
  logic [RNUM_W-1:0]  round_num_q;
  logic [SCORE_W-1:0] score_a;
  logic [SCORE_W-1:0] score_b;

  logic              start_ok;
  logic              guess_ok;
  logic              full_match;
  logic              last_guess;
  logic [GNUM_W-1:0] guess_num_next;
  logic [1:0]        inc_a;
  logic [1:0]        inc_b;

  // A start is only honoured between games; it also clears both scores.
  assign start_ok = bus.start && (state == IDLE || state == GAME_OVER);
  assign guess_ok = bus.guess_valid && (state == GUESS);

  // exact values above DIGITS simply fail this compare, i.e. count as a miss.
  assign full_match     = (bus.exact == EXACT_W'(DIGITS));
  assign guess_num_next = guess_num_q + 1'b1;
  assign last_guess     = (guess_num_next == GNUM_W'(MAX_GUESSES));

  // Every consumed guess earns the maker 1; a breaker who exhausts all
  // guesses without a match earns the maker a bonus point on top.
  always_comb begin
    inc_a = 2'd0;
    inc_b = 2'd0;
    if (guess_ok) begin
      if (active_p_q == PLAYER_A) inc_a = (!full_match && last_guess) ? 2'd2 : 2'd1;
      else                        inc_b = (!full_match && last_guess) ? 2'd2 : 2'd1;
    end
  end

  sat_score_counter #(.SCORE_W(SCORE_W)) u_score_a (
    .clk   (clk),
    .reset (reset),
    .clear (start_ok),
    .inc   (inc_a),
    .score (score_a)
  );

  sat_score_counter #(.SCORE_W(SCORE_W)) u_score_b (
    .clk   (clk),
    .reset (reset),
    .clear (start_ok),
    .inc   (inc_b),
    .score (score_b)
  );

  // Phase outputs are registered alongside the state so they always equal a
  // decode of the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      take_code_q  <= 1'b0;
      guess_req_q  <= 1'b0;
      round_over_q <= 1'b0;
      game_over_q  <= 1'b0;
      active_p_q   <= PLAYER_A;
      winner_q     <= WIN_NONE;
      guess_num_q  <= '0;
      round_num_q  <= '0;
    end else begin
      round_over_q <= 1'b0;
      case (state)
        IDLE, GAME_OVER: begin
          if (bus.start) begin
            state       <= CODE;
            take_code_q <= 1'b1;
            game_over_q <= 1'b0;
            winner_q    <= WIN_NONE;
            active_p_q  <= PLAYER_A;
            guess_num_q <= '0;
            round_num_q <= '0;
          end
        end
        CODE: begin
          if (bus.code_valid) begin
            state       <= GUESS;
            take_code_q <= 1'b0;
            guess_req_q <= 1'b1;
            guess_num_q <= '0;
          end
        end
        GUESS: begin
          if (bus.guess_valid) begin
            guess_num_q <= guess_num_next;
            if (full_match || last_guess) begin
              state        <= ROUND_END;
              guess_req_q  <= 1'b0;
              round_over_q <= 1'b1;
            end
          end
        end
        ROUND_END: begin
          round_num_q <= round_num_q + 1'b1;
          if (round_num_q == RNUM_W'(ROUNDS - 1)) begin
            state       <= GAME_OVER;
            game_over_q <= 1'b1;
            // Scores are already final: the last increment landed on the
            // edge that entered ROUND_END.
            winner_q    <= winner_of(16'(score_a), 16'(score_b));
          end else begin
            state       <= CODE;
            take_code_q <= 1'b1;
            active_p_q  <= ~active_p_q;
          end
        end
        default: begin
          state        <= IDLE;
          take_code_q  <= 1'b0;
          guess_req_q  <= 1'b0;
          game_over_q  <= 1'b0;
          winner_q     <= WIN_NONE;
        end
      endcase
    end
  end

  assign bus.take_code  = take_code_q;
  assign bus.guess_req  = guess_req_q;
  assign bus.round_over = round_over_q;
  assign bus.game_over  = game_over_q;
  assign bus.active_p   = active_p_q;
  assign bus.winner     = winner_q;
  assign bus.guess_num  = guess_num_q;
  assign bus.round_num  = round_num_q;
  assign bus.score_a    = score_a;
  assign bus.score_b    = score_b;

endmodule

// File: tb/tb_mastermind_game_ctrl.sv
// tb/tb_mastermind_game_ctrl.sv - directed self-checking bench for mastermind_game_ctrl

module tb_mastermind_game_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  // u_dut uses SCORE_W=5; u_sat uses SCORE_W=3 and sees identical inputs.
  mastermind_game_ctrl_if #(.DIGITS(4), .MAX_GUESSES(7), .ROUNDS(4), .SCORE_W(5)) bus ();
  mastermind_game_ctrl_if #(.DIGITS(4), .MAX_GUESSES(7), .ROUNDS(4), .SCORE_W(3)) bus3 ();

  assign bus3.start       = bus.start;
  assign bus3.code_valid  = bus.code_valid;
  assign bus3.guess_valid = bus.guess_valid;
  assign bus3.exact       = bus.exact;

  mastermind_game_ctrl #(.DIGITS(4), .MAX_GUESSES(7), .ROUNDS(4), .SCORE_W(5)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  mastermind_game_ctrl #(.DIGITS(4), .MAX_GUESSES(7), .ROUNDS(4), .SCORE_W(3)) u_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_tests++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Step past the next rising edge; outputs are stable 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic pulse_code();
    bus.code_valid = 1'b1;
    tick();
    bus.code_valid = 1'b0;
  endtask

  task automatic pulse_guess(input logic [2:0] e);
    bus.guess_valid = 1'b1;
    bus.exact       = e;
    tick();
    bus.guess_valid = 1'b0;
    bus.exact       = 3'd0;
  endtask

  // Code, `misses` non-matching guesses, optional full match, then leave ROUND_END.
  task automatic run_round(input int misses, input bit hit, input logic [2:0] miss_exact);
    pulse_code();
    for (int i = 0; i < misses; i++) pulse_guess(miss_exact);
    if (hit) pulse_guess(3'd4);
    tick();
  endtask

  initial begin
    reset           = 1'b1;
    bus.start       = 1'b0;
    bus.code_valid  = 1'b0;
    bus.guess_valid = 1'b0;
    bus.exact       = 3'd0;
    tick();
    tick();

    check("rst_take_code", 32'(bus.take_code), 0);
    check("rst_guess_req", 32'(bus.guess_req), 0);
    check("rst_game_over", 32'(bus.game_over), 0);
    check("rst_winner",    32'(bus.winner), 0);
    check("rst_score_a",   32'(bus.score_a), 0);
    check("rst_round_num", 32'(bus.round_num), 0);
    reset = 1'b0;
    tick();

    // ---------------- game 1: B lasts longer ----------------
    pulse_start();
    check("g1_take_code", 32'(bus.take_code), 1);
    check("g1_active_p0", 32'(bus.active_p), 0);

    // guess_valid in CODE is ignored
    pulse_guess(3'd4);
    check("ign_gv_take_code", 32'(bus.take_code), 1);
    check("ign_gv_score_a",   32'(bus.score_a), 0);
    check("ign_gv_guess_num", 32'(bus.guess_num), 0);

    // code_valid and guess_valid together in CODE: only the code is taken
    bus.guess_valid = 1'b1;
    bus.exact       = 3'd4;
    pulse_code();
    bus.guess_valid = 1'b0;
    bus.exact       = 3'd0;
    check("both_guess_req", 32'(bus.guess_req), 1);
    check("both_score_a",   32'(bus.score_a), 0);
    check("both_guess_num", 32'(bus.guess_num), 0);

    pulse_guess(3'd1);
    check("r1_g1_guess_num", 32'(bus.guess_num), 1);
    check("r1_g1_score_a",   32'(bus.score_a), 1);

    // code_valid and start during GUESS are ignored
    pulse_code();
    pulse_start();
    check("ign_guess_req", 32'(bus.guess_req), 1);
    check("ign_guess_num", 32'(bus.guess_num), 1);
    check("ign_score_a",   32'(bus.score_a), 1);
    check("ign_round_num", 32'(bus.round_num), 0);

    pulse_guess(3'd2);
    pulse_guess(3'd4);
    check("r1_round_over", 32'(bus.round_over), 1);
    check("r1_score_a",    32'(bus.score_a), 3);
    check("r1_guess_num",  32'(bus.guess_num), 3);
    check("r1_take_code0", 32'(bus.take_code), 0);
    tick();
    check("r1_round_over_off", 32'(bus.round_over), 0);
    check("r1_take_code1",     32'(bus.take_code), 1);
    check("r1_active_p",       32'(bus.active_p), 1);
    check("r1_round_num",      32'(bus.round_num), 1);

    // round 2: maker B, breaker misses all 7
    pulse_code();
    for (int i = 0; i < 7; i++) pulse_guess(3'd0);
    check("r2_round_over", 32'(bus.round_over), 1);
    check("r2_guess_num",  32'(bus.guess_num), 7);
    check("r2_score_b",    32'(bus.score_b), 8);
    check("r2_sat_b",      32'(bus3.score_b), 7);
    tick();
    check("r2_active_p",  32'(bus.active_p), 0);
    check("r2_round_num", 32'(bus.round_num), 2);

    // round 3: maker A, misses reported as exact=5 (above DIGITS)
    run_round(7, 1'b0, 3'd5);
    check("r3_score_a", 32'(bus.score_a), 11);
    check("r3_sat_a",   32'(bus3.score_a), 7);

    // round 4: maker B, misses reported as exact=7
    run_round(7, 1'b0, 3'd7);
    check("g1_game_over", 32'(bus.game_over), 1);
    check("g1_score_b",   32'(bus.score_b), 16);
    check("g1_winner",    32'(bus.winner), 2);
    check("g1_round_num", 32'(bus.round_num), 4);
    check("g1_take_code", 32'(bus.take_code), 0);
    check("g1_sat_winner", 32'(bus3.winner), 3);

    // ---------------- restart from GAME_OVER ----------------
    pulse_start();
    check("rs_score_a",   32'(bus.score_a), 0);
    check("rs_score_b",   32'(bus.score_b), 0);
    check("rs_sat_b",     32'(bus3.score_b), 0);
    check("rs_take_code", 32'(bus.take_code), 1);
    check("rs_active_p",  32'(bus.active_p), 0);
    check("rs_game_over", 32'(bus.game_over), 0);
    check("rs_winner",    32'(bus.winner), 0);
    check("rs_round_num", 32'(bus.round_num), 0);

    // ---------------- game 2: A lasts longer ----------------
    run_round(7, 1'b0, 3'd0);
    run_round(0, 1'b1, 3'd0);
    run_round(0, 1'b1, 3'd0);
    run_round(0, 1'b1, 3'd0);
    check("g2_score_a", 32'(bus.score_a), 9);
    check("g2_score_b", 32'(bus.score_b), 2);
    check("g2_winner",  32'(bus.winner), 1);
    check("g2_sat_winner", 32'(bus3.winner), 1);

    // ---------------- game 3: tie ----------------
    pulse_start();
    for (int r = 0; r < 4; r++) run_round(0, 1'b1, 3'd0);
    check("g3_game_over", 32'(bus.game_over), 1);
    check("g3_score_a",   32'(bus.score_a), 2);
    check("g3_winner",    32'(bus.winner), 3);

    // ---------------- reset mid-round ----------------
    pulse_start();
    pulse_code();
    pulse_guess(3'd1);
    pulse_guess(3'd2);
    pulse_guess(3'd3);
    check("mr_score_a", 32'(bus.score_a), 3);
    reset = 1'b1;
    tick();
    check("mr_round_over", 32'(bus.round_over), 0);
    check("mr_guess_req",  32'(bus.guess_req), 0);
    check("mr_take_code",  32'(bus.take_code), 0);
    check("mr_score_a0",   32'(bus.score_a), 0);
    check("mr_guess_num",  32'(bus.guess_num), 0);
    reset = 1'b0;
    tick();
    check("mr_idle_round_over", 32'(bus.round_over), 0);
    check("mr_idle_take_code",  32'(bus.take_code), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
